// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one multi-lane ALU datapath between N_REQ requesters. One operation is
// in flight at a time: a round-robin winner is accepted in IDLE, its operands
// are driven to the ALU and held for ALU_LAT+1 cycles (EXEC), then the captured
// result is offered back to that requester until it accepts it (RESP).
//
// Ports:
//   clk, arst        clock; synchronous active-high reset
//   req_valid/ready  per-requester operation handshake (ready is combinational,
//                    at most one bit set, only in IDLE)
//   req_a/b/sel      packed per-requester operands and opcode
//   alu_a/b/select   registered operands/opcode to the shared ALU
//   alu_out, alu_a_greater/equal/less, alu_carry_out  ALU results
//   rsp_valid/ready  per-requester response handshake (valid is one-hot)
//   rsp_out/flags/carry  captured ALU result, flags {greater,equal,less}, carry
//   busy             registered, high while in EXEC or RESP
module alu_share_arbiter #(
    parameter int WIDTH   = 4,
    parameter int N_ALU   = 4,
    parameter int N_REQ   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH*N_ALU-1:0] req_a,
    input  logic [N_REQ*WIDTH*N_ALU-1:0] req_b,
    input  logic [N_REQ*3-1:0]       req_sel,
    output logic [WIDTH*N_ALU-1:0]   alu_a,
    output logic [WIDTH*N_ALU-1:0]   alu_b,
    output logic [2:0]               alu_select,
    input  logic [WIDTH*N_ALU*8-1:0] alu_out,
    input  logic                     alu_a_greater,
    input  logic                     alu_a_equal,
    input  logic                     alu_a_less,
    input  logic                     alu_carry_out,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [WIDTH*N_ALU*8-1:0] rsp_out,
    output logic [2:0]               rsp_flags,
    output logic                     rsp_carry,
    output logic                     busy
);

    localparam int DW   = WIDTH * N_ALU;
    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNTW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_n_s;
    logic [IDXW-1:0]     last_grant_r;
    logic [IDXW-1:0]     cur_r;
    logic [CNTW-1:0]     cnt_r;
    logic [DW-1:0]       alu_a_r;
    logic [DW-1:0]       alu_b_r;
    logic [2:0]          alu_sel_r;
    logic [N_REQ-1:0]    rsp_valid_r;
    logic [DW*8-1:0]     rsp_out_r;
    logic [2:0]          rsp_flags_r;
    logic                rsp_carry_r;
    logic                busy_r;

    logic                grant_found_s;
    logic [IDXW-1:0]     grant_idx_s;
    logic [IDXW:0]       cand_s;
    logic [N_REQ-1:0]    req_ready_s;
    logic                accept_s;

    // Round-robin search: first valid requester after last_grant, wrapping.
    // cand_s carries one extra bit so last_grant + k never overflows before
    // the wrap subtraction.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {IDXW{1'b0}};
        cand_s        = {(IDXW+1){1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = {1'b0, last_grant_r} + (IDXW+1)'(k);
            if (cand_s >= (IDXW+1)'(N_REQ)) begin
                cand_s = cand_s - (IDXW+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_found_s && req_valid[cand_s[IDXW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[IDXW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Next-state and combinational accept strobe.
    always_comb begin
        state_n_s   = state_r;
        req_ready_s = {N_REQ{1'b0}};
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    req_ready_s[grant_idx_s] = 1'b1;
                    accept_s                 = 1'b1;
                    state_n_s                = ST_EXEC;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == {CNTW{1'b0}}) begin
                    state_n_s = ST_RESP;
                end else begin
                    state_n_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (rsp_ready[cur_r]) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_RESP;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State register plus operand, counter and response datapath registers.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= IDXW'(N_REQ - 1);
            cur_r        <= {IDXW{1'b0}};
            cnt_r        <= {CNTW{1'b0}};
            alu_a_r      <= {DW{1'b0}};
            alu_b_r      <= {DW{1'b0}};
            alu_sel_r    <= 3'd0;
            rsp_valid_r  <= {N_REQ{1'b0}};
            rsp_out_r    <= {(DW*8){1'b0}};
            rsp_flags_r  <= 3'd0;
            rsp_carry_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_n_s;
            busy_r  <= (state_n_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        alu_a_r   <= req_a[grant_idx_s*DW +: DW];
                        alu_b_r   <= req_b[grant_idx_s*DW +: DW];
                        alu_sel_r <= req_sel[grant_idx_s*3 +: 3];
                        cur_r     <= grant_idx_s;
                        cnt_r     <= CNTW'(ALU_LAT);
                    end else begin
                        cur_r <= cur_r;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r != {CNTW{1'b0}}) begin
                        cnt_r <= cnt_r - CNTW'(1);
                    end else begin
                        rsp_out_r   <= alu_out;
                        rsp_flags_r <= {alu_a_greater, alu_a_equal, alu_a_less};
                        rsp_carry_r <= alu_carry_out;
                        rsp_valid_r <= {{(N_REQ-1){1'b0}}, 1'b1} << cur_r;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[cur_r]) begin
                        last_grant_r <= cur_r;
                        rsp_valid_r  <= {N_REQ{1'b0}};
                    end else begin
                        rsp_valid_r <= rsp_valid_r;
                    end
                end
                default: begin
                    rsp_valid_r <= {N_REQ{1'b0}};
                end
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_select = alu_sel_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_out    = rsp_out_r;
    assign rsp_flags  = rsp_flags_r;
    assign rsp_carry  = rsp_carry_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: randomized and directed traffic, a
// behavioural ALU with ALU_LAT cycles of latency, and a scoreboard monitor
// that predicts grants, operand hold, response timing and response contents.
module tb_alu_share_arbiter;

    localparam int WIDTH   = 4;
    localparam int N_ALU   = 4;
    localparam int N_REQ   = 4;
    localparam int ALU_LAT = 1;
    localparam int DW      = WIDTH * N_ALU;

    typedef struct packed {
        logic [DW*8-1:0] out;
        logic [2:0]      flags;
        logic            carry;
    } alu_res_t;

    typedef struct {
        int          id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    sel;
        alu_res_t      res;
    } exp_t;

    logic                  clk;
    logic                  arst;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*DW-1:0]   req_a;
    logic [N_REQ*DW-1:0]   req_b;
    logic [N_REQ*3-1:0]    req_sel;
    logic [DW-1:0]         alu_a;
    logic [DW-1:0]         alu_b;
    logic [2:0]            alu_select;
    logic [DW*8-1:0]       alu_out;
    logic                  alu_a_greater;
    logic                  alu_a_equal;
    logic                  alu_a_less;
    logic                  alu_carry_out;
    logic [N_REQ-1:0]      rsp_valid;
    logic [N_REQ-1:0]      rsp_ready;
    logic [DW*8-1:0]       rsp_out;
    logic [2:0]            rsp_flags;
    logic                  rsp_carry;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(
        .WIDTH(WIDTH), .N_ALU(N_ALU), .N_REQ(N_REQ), .ALU_LAT(ALU_LAT)
    ) dut (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_out(alu_out),
        .alu_a_greater(alu_a_greater), .alu_a_equal(alu_a_equal), .alu_a_less(alu_a_less),
        .alu_carry_out(alu_carry_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_flags(rsp_flags), .rsp_carry(rsp_carry),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: opcode-selected 16-bit result, replicated with a lane
    // offset across the 8 output words; flags compare a with b.
    function automatic alu_res_t alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [2:0] sel);
        alu_res_t      r;
        logic [DW:0]   sum;
        logic [DW-1:0] v;
        sum = {1'b0, a} + {1'b0, b};
        case (sel)
            3'd0: v = a + b;
            3'd1: v = a - b;
            3'd2: v = a & b;
            3'd3: v = a | b;
            3'd4: v = a ^ b;
            3'd5: v = ~a;
            3'd6: v = a << 1;
            default: v = a >> 1;
        endcase
        for (int k = 0; k < 8; k++) r.out[k*DW +: DW] = v + DW'(k * 257);
        r.flags = {a > b, a == b, a < b};
        r.carry = sum[DW];
        return r;
    endfunction

    alu_res_t alu_now;
    alu_res_t alu_drv;
    assign alu_now = alu_ref(alu_a, alu_b, alu_select);

    generate
        if (ALU_LAT == 0) begin : g_comb_alu
            assign alu_drv = alu_now;
        end else begin : g_pipe_alu
            alu_res_t pipe [ALU_LAT];
            always @(posedge clk) begin
                pipe[0] <= alu_now;
                for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
            end
            assign alu_drv = pipe[ALU_LAT-1];
        end
    endgenerate

    assign alu_out       = alu_drv.out;
    assign alu_a_greater = alu_drv.flags[2];
    assign alu_a_equal   = alu_drv.flags[1];
    assign alu_a_less    = alu_drv.flags[0];
    assign alu_carry_out = alu_drv.carry;

    task automatic chk(input string nm, input logic [DW*8-1:0] act, input logic [DW*8-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N_REQ-1:0] v);
        int i;
        for (int k = 1; k <= N_REQ; k++) begin
            i = (last + k) % N_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Scoreboard / reference state
    exp_t sb_q[$];
    int   last_grant = N_REQ - 1;
    bit   model_idle = 1'b1;
    int   age        = 0;
    bit   chk_zero   = 1'b0;

    // Monitor: predicts and compares every DUT-visible behaviour each cycle.
    always @(negedge clk) begin
        int               g;
        logic [N_REQ-1:0] exp_rdy;
        logic [N_REQ-1:0] exp_vld;
        exp_t             e;
        if (arst) begin
            sb_q.delete();
            model_idle = 1'b1;
            last_grant = N_REQ - 1;
            age        = 0;
            chk_zero   = 1'b1;
        end else begin
            if (chk_zero) begin
                chk("rst_alu_a", alu_a, '0);
                chk("rst_alu_b", alu_b, '0);
                chk("rst_alu_select", alu_select, '0);
                chk("rst_rsp_valid", rsp_valid, '0);
                chk("rst_rsp_out", rsp_out, '0);
                chk("rst_rsp_flags", {rsp_flags, rsp_carry}, '0);
                chk_zero = 1'b0;
            end
            chk("busy", busy, !model_idle);
            if (!model_idle) age++;

            exp_rdy = '0;
            g       = -1;
            if (model_idle) begin
                g = rr_pick(last_grant, req_valid);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", req_ready, exp_rdy);

            if (!model_idle && age <= ALU_LAT + 1 && sb_q.size() > 0) begin
                chk("hold_alu_a", alu_a, sb_q[0].a);
                chk("hold_alu_b", alu_b, sb_q[0].b);
                chk("hold_alu_select", alu_select, sb_q[0].sel);
            end

            exp_vld = '0;
            if (!model_idle && age >= ALU_LAT + 2 && sb_q.size() > 0) exp_vld[sb_q[0].id] = 1'b1;
            chk("rsp_valid", rsp_valid, exp_vld);
            if (exp_vld != '0) begin
                chk("rsp_out", rsp_out, sb_q[0].res.out);
                chk("rsp_flags", rsp_flags, sb_q[0].res.flags);
                chk("rsp_carry", rsp_carry, sb_q[0].res.carry);
                if (rsp_ready[sb_q[0].id]) begin
                    last_grant = sb_q[0].id;
                    void'(sb_q.pop_front());
                    model_idle = 1'b1;
                end
            end

            if (g >= 0) begin
                e.id  = g;
                e.a   = req_a[g*DW +: DW];
                e.b   = req_b[g*DW +: DW];
                e.sel = req_sel[g*3 +: 3];
                e.res = alu_ref(e.a, e.b, e.sel);
                sb_q.push_back(e);
                model_idle = 1'b0;
                age        = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*DW +: DW] = DW'($urandom);
            req_b[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? req_a[i*DW +: DW] : DW'($urandom);
            req_sel[i*3 +: 3] = 3'($urandom);
        end
    endtask

    // Wait (bounded) until any bit of mask is granted, then move past that edge.
    task automatic wait_grant(input logic [N_REQ-1:0] mask, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(negedge clk);
            if ((req_ready & mask) != '0) seen = 1'b1;
        end
        chk("grant_timeout", seen, 1'b1);
        step();
    endtask

    initial begin
        arst      = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        step();
        step();
        arst = 1'b0;
        step();

        // Single request from requester 2
        req_a[2*DW +: DW] = 16'h00A5;
        req_b[2*DW +: DW] = 16'h0003;
        req_sel[6 +: 3]   = 3'd1;
        req_valid         = 4'b0100;
        rsp_ready         = 4'b0100;
        wait_grant(4'b0100, 10);
        req_valid = '0;
        repeat (6) step();

        // Round-robin with everyone continuously valid
        req_valid = '1;
        rsp_ready = '1;
        repeat (6 * (ALU_LAT + 3)) begin
            rand_ops();
            step();
        end

        // Wrap priority: serve 3, then 0 must win over 3
        req_valid = 4'b1000;
        wait_grant(4'b1000, 4 * (ALU_LAT + 3));
        req_valid = 4'b1001;
        repeat (3 * (ALU_LAT + 3)) step();

        // Backpressure in RESP
        req_valid = '1;
        rsp_ready = '0;
        rand_ops();
        repeat (ALU_LAT + 3 + 10) step();
        rsp_ready = '1;
        repeat (2 * (ALU_LAT + 3)) step();

        // Reset during EXEC
        req_valid = '1;
        wait_grant('1, 4 * (ALU_LAT + 3));
        arst = 1'b1;
        step();
        arst = 1'b0;
        repeat (3 * (ALU_LAT + 3)) step();

        // Random traffic with occasional resets
        repeat (400) begin
            rand_ops();
            req_valid = N_REQ'($urandom);
            rsp_ready = N_REQ'($urandom);
            arst      = ($urandom_range(0, 79) == 0);
            step();
        end

        // Drain
        arst      = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        repeat (4 * (ALU_LAT + 3)) step();
        chk("drain_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multi-lane ALU datapath (N_ALU lanes of WIDTH bits, 3-bit opcode select, compare flags, carry) between N_REQ requesters.
- Accepts one operation at a time over a per-requester valid/ready handshake.
- Drives and holds the ALU operands for a fixed latency, captures the result, and returns it to the originating requester over a per-requester valid/ready response channel.
- Sits between the requester agents and the ALU instance in the datapath top level.

Parameters:
WIDTH, 4, bits per ALU lane
N_ALU, 4, number of ALU lanes; operand width DW = WIDTH*N_ALU
N_REQ, 4, number of requesters (>=2)
ALU_LAT, 1, ALU result latency in cycles after operands are stable (0 = combinational ALU)

Ports:
clk  in  1  single clock, all logic on rising edge
arst  in  1  reset, synchronous, active-high
req_valid  in  N_REQ  per-requester operation request
req_ready  out  N_REQ  per-requester accept; at most one bit set
req_a  in  N_REQ*DW  packed operand A; requester i at [i*DW +: DW]
req_b  in  N_REQ*DW  packed operand B
req_sel  in  N_REQ*3  packed opcode select
alu_a  out  DW  operand A to ALU
alu_b  out  DW  operand B to ALU
alu_select  out  3  opcode to ALU
alu_out  in  DW*8  ALU result bus
alu_a_greater, alu_a_equal, alu_a_less  in  1 each  ALU compare flags
alu_carry_out  in  1  ALU carry
rsp_valid  out  N_REQ  one-hot response valid to the granted requester
rsp_ready  in  N_REQ  per-requester response accept
rsp_out  out  DW*8  captured alu_out
rsp_flags  out  3  captured {greater, equal, less}
rsp_carry  out  1  captured carry
busy  out  1  high in EXEC and RESP

Behaviour:
- Reset (arst high at a rising edge):
  - State goes to IDLE.
  - All registered outputs go to 0: alu_a, alu_b, alu_select, rsp_*, busy.
  - last_grant is set to N_REQ-1, so requester 0 has first priority.
  - Any in-flight operation is dropped and produces no response.
- Reset takes priority over every other event in the same cycle.
- States: IDLE, EXEC, RESP.
- IDLE:
  - g is the first i with req_valid[i]=1, searching from (last_grant+1) mod N_REQ upward with wrap-around.
  - req_ready[g]=1 combinationally in the same cycle; req_ready is 0 in all other states.
  - On that edge: latch req_a/req_b/req_sel of g into alu_a/alu_b/alu_select, latch g as cur, set cnt=ALU_LAT, go to EXEC.
  - If no request is valid, stay in IDLE and hold the outputs.
- EXEC:
  - alu_a/alu_b/alu_select are held stable.
  - If cnt != 0, decrement cnt.
  - If cnt == 0: capture alu_out, the flags and the carry into the rsp_* registers, then go to RESP.
  - EXEC therefore lasts ALU_LAT+1 cycles.
- RESP:
  - rsp_valid = one-hot(cur); rsp_out/rsp_flags/rsp_carry are held stable.
  - On rsp_ready[cur]=1: set last_grant=cur, rsp_valid to 0, go to IDLE.
  - rsp_ready bits of other requesters, and rsp_ready outside RESP, are ignored.
- Minimum issue period is ALU_LAT+3 cycles.
- Requests are sampled only at the accept edge. A requester may drop req_valid before it is granted, with no side effect.
- A requester whose response is pending may keep req_valid high; it is re-arbitrated only once the FSM returns to IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0,...
- busy = (state != IDLE), registered.

Test Plan:
- Reset: hold arst high 2 cycles mid-random traffic -> all outputs 0, busy=0, req_ready=0.
- Single request (defaults): requester 2 with a=16'h00A5, b=16'h0003, sel=3'd1 at t0 ->
  - req_ready=4'b0100 at t0.
  - alu_a=16'h00A5 and alu_select=1 held over t1-t2.
  - rsp_valid=4'b0100 from t3; rsp_out/flags/carry match the ALU reference model; rsp_ready at t3 -> IDLE at t4.
- Round-robin: all req_valid=4'b1111 continuously, rsp_ready=4'b1111 -> grants 0,1,2,3,0 at t0, t4, t8, t12, t16.
- Wrap priority: after serving requester 3, assert req_valid=4'b1001 -> requester 0 granted next; then requester 3.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and rsp_* stable, req_ready=0 throughout, no new grant until handshake.
- Reset mid-EXEC: assert arst for 1 cycle during EXEC -> next cycle IDLE, no rsp_valid ever, and the next grant goes to requester 0 if valid.
- ALU_LAT=0 build: repeat the round-robin case -> grant period 3 cycles; results captured in the single EXEC cycle.
